fir_out_requant: RTL and testbench

Downstream stage of fir_inst. Consumes the signed 39-bit filter output (data_out/data_out_vld of fir_inst) and produces a 16-bit signed sample stream. Processing order: optional integer decimation, round-half-up requantisation by a fixed right shift, then saturation. Also keeps a sticky saturation flag and a saturating event counter for bring-up and debug.

---
 rtl/fir_out_requant.sv | 97 +++++++++
 tb/tb_fir_out_requant.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_requant.sv
// Requantiser behind fir_inst: decimate, round-half-up shift, saturate to OUT_W.
// Sticky clip flag and saturating clip counter for bring-up visibility.
module fir_out_requant #(
   parameter int IN_W  = 39,
   parameter int OUT_W = 16,
   parameter int SHIFT = 22,
   parameter int DEC   = 4,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    data_in_vld,
   input  logic signed [IN_W-1:0]  data_in,
   input  logic                    clr_sat,
   output logic signed [OUT_W-1:0] data_out,
   output logic                    data_out_vld,
   output logic                    sat_flag,
   output logic [CNT_W-1:0]        sat_cnt
);

   localparam int QW  = IN_W + 1 - SHIFT;
   localparam int PHW = (DEC > 1) ? $clog2(DEC) : 1;

   localparam logic signed [IN_W:0] RND =
      (IN_W+1)'(1) << (SHIFT - 1);
   localparam logic signed [QW-1:0] QMAX =
      QW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
   localparam logic signed [QW-1:0] QMIN = ~QMAX;
   localparam logic signed [OUT_W-1:0] OMAX =
      {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] OMIN = ~OMAX;

   logic [PHW-1:0]        r_ph;
   logic                  r_v1;
   logic signed [QW-1:0]  r_q;

   logic signed [IN_W:0]  w_sum;
   logic signed [QW-1:0]  w_q;
   logic                  w_unused;
   logic                  w_keep;
   logic                  w_ph_last;
   logic                  w_hi;
   logic                  w_lo;
   logic                  w_sat;

   // Extra headroom bit keeps the rounding offset from overflowing.
   assign w_sum     = {data_in[IN_W-1], data_in} + RND;
   assign w_q       = w_sum[IN_W:SHIFT];
   assign w_unused  = ^w_sum[SHIFT-1:0];

   assign w_keep    = data_in_vld & (r_ph == '0);
   assign w_ph_last = (r_ph == PHW'(DEC - 1));

   assign w_hi  = (r_q > QMAX);
   assign w_lo  = (r_q < QMIN);
   assign w_sat = r_v1 & (w_hi | w_lo);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ph         <= '0;
         r_v1         <= 1'b0;
         r_q          <= '0;
         data_out     <= '0;
         data_out_vld <= 1'b0;
         sat_flag     <= 1'b0;
         sat_cnt      <= '0;
      end else begin
         if (data_in_vld)
            r_ph <= w_ph_last ? '0 : r_ph + PHW'(1);

         r_v1 <= w_keep;
         if (w_keep)
            r_q <= w_q;

         data_out_vld <= r_v1;
         if (r_v1) begin
            if (w_hi)
               data_out <= OMAX;
            else if (w_lo)
               data_out <= OMIN;
            else
               data_out <= r_q[OUT_W-1:0];
         end

         // A clip on the clearing edge survives the clear.
         if (clr_sat) begin
            sat_flag <= w_sat;
            sat_cnt  <= w_sat ? CNT_W'(1) : '0;
         end else if (w_sat) begin
            sat_flag <= 1'b1;
            if (sat_cnt != '1)
               sat_cnt <= sat_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fir_out_requant.sv
// Scoreboard bench: two instances (DEC=1/CNT_W=4 and DEC=4/CNT_W=16) share
// one input stream; a real-arithmetic model predicts each output stream.
module tb_fir_out_requant;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                vld = 1'b0;
   logic                clr = 1'b0;
   logic signed [38:0]  din = '0;

   logic signed [15:0]  d1, d4;
   logic                v1, v4, f1, f4;
   logic [3:0]          c1;
   logic [15:0]         c4;

   always #5 clk = ~clk;

   fir_out_requant #(.DEC(1), .CNT_W(4)) u1 (
      .clk(clk), .rst(rst), .data_in_vld(vld), .data_in(din),
      .clr_sat(clr), .data_out(d1), .data_out_vld(v1),
      .sat_flag(f1), .sat_cnt(c1)
   );

   fir_out_requant #(.DEC(4), .CNT_W(16)) u4 (
      .clk(clk), .rst(rst), .data_in_vld(vld), .data_in(din),
      .clr_sat(clr), .data_out(d4), .data_out_vld(v4),
      .sat_flag(f4), .sat_cnt(c4)
   );

   typedef struct {
      int     val;
      bit     clip;
      longint due;
   } exp_t;

   exp_t   q [2][$];
   int     total = 0;
   int     bad   = 0;
   longint cyc   = 0;
   int     nacc  [2] = '{0, 0};
   int     decf  [2] = '{1, 4};
   int     cmax  [2] = '{15, 65535};
   int     e_flag[2] = '{0, 0};
   int     e_cnt [2] = '{0, 0};
   int     e_last[2] = '{0, 0};
   bit     rst_pend = 1'b1;
   bit     clr_pend = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // floor(x/2^22 + 0.5), then clamp to the 16-bit signed range
   function automatic exp_t model(longint x, longint due);
      exp_t   e;
      real    r;
      longint qv;
      r  = $floor(real'(x) / 4194304.0 + 0.5);
      qv = longint'(r);
      e.due  = due;
      e.clip = (qv > 32767) || (qv < -32768);
      if (qv > 32767)       e.val = 32767;
      else if (qv < -32768) e.val = -32768;
      else                  e.val = int'(qv);
      return e;
   endfunction

   task automatic chk(string nm, int id, longint act, longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s u%0d: got %0d want %0d", nm, id, act, exp);
      end
   endtask

   task automatic drive(longint x, bit v, bit c);
      din = x[38:0];
      vld = v;
      clr = c;
      if (v) begin
         for (int id = 0; id < 2; id++) begin
            if (nacc[id] % decf[id] == 0)
               q[id].push_back(model(x, cyc + 2));
            nacc[id]++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n);
      repeat (n) drive(0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      vld = 1'b0;
      clr = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int id = 0; id < 2; id++) begin
         q[id].delete();
         nacc[id] = 0;
      end
   endtask

   always @(negedge clk) begin
      for (int id = 0; id < 2; id++) begin
         int   dv, cv, sat;
         bit   vv, fv;
         exp_t e;
         dv  = (id == 0) ? int'(d1) : int'(d4);
         vv  = (id == 0) ? v1 : v4;
         fv  = (id == 0) ? f1 : f4;
         cv  = (id == 0) ? int'(c1) : int'(c4);
         sat = 0;
         if (rst_pend) begin
            e_flag[id] = 0;
            e_cnt[id]  = 0;
            e_last[id] = 0;
            chk("vld_in_reset", id, vv, 0);
         end else begin
            while (q[id].size() > 0 && q[id][0].due < cyc) begin
               e = q[id].pop_front();
               total++;
               bad++;
               $display("FAIL missing u%0d: got none want %0d", id, e.val);
            end
            if (vv) begin
               if (q[id].size() > 0 && q[id][0].due == cyc) begin
                  e = q[id].pop_front();
                  chk("data", id, dv, e.val);
                  e_last[id] = e.val;
                  sat = e.clip ? 1 : 0;
               end else begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_vld u%0d: got %0d want none", id, dv);
                  e_last[id] = dv;
               end
            end
            if (clr_pend) begin
               e_flag[id] = sat;
               e_cnt[id]  = sat;
            end else if (sat != 0) begin
               e_flag[id] = 1;
               if (e_cnt[id] < cmax[id]) e_cnt[id]++;
            end
         end
         chk("hold", id, dv, e_last[id]);
         chk("sat_flag", id, fv, e_flag[id]);
         chk("sat_cnt", id, cv, e_cnt[id]);
      end
      rst_pend = rst;
      clr_pend = clr;
   end

   longint BP = 64'sd137436856320;
   longint BN = -64'sd137441050624;
   longint X38 = 64'sd274877906943;

   initial begin
      longint x;
      logic [63:0] rr;
      @(posedge clk);
      #1;
      do_reset();

      drive(4194304, 1, 0);
      drive(2097152, 1, 0);
      drive(2097151, 1, 0);
      drive(-2097152, 1, 0);
      drive(-2097153, 1, 0);
      idle(3);
      chk("round_flag", 0, f1, 0);

      drive(X38, 1, 0);
      drive(-X38 - 1, 1, 0);
      drive(BP, 1, 0);
      drive(BP - 1, 1, 0);
      idle(3);
      chk("bound_cnt", 0, c1, 3);
      chk("bound_flag", 0, f1, 1);

      do_reset();
      for (int k = 1; k <= 9; k++) drive(longint'(k) * 4194304, 1, 0);
      idle(3);
      do_reset();
      for (int k = 1; k <= 9; k++) begin
         drive(longint'(k) * 4194304, 1, 0);
         idle(1);
      end
      idle(3);

      do_reset();
      drive(5 * 4194304, 1, 0);
      do_reset();
      chk("rst_cnt", 1, c4, 0);
      drive(7 * 4194304, 1, 0);
      idle(3);
      chk("post_rst_out", 1, d4, 7);

      do_reset();
      repeat (20) drive(X38, 1, 0);
      idle(3);
      chk("cnt_stop", 0, c1, 15);
      drive(X38, 1, 0);
      drive(0, 0, 1);
      idle(2);
      chk("clr_conc_cnt", 0, c1, 1);
      chk("clr_conc_flag", 0, f1, 1);
      drive(0, 0, 1);
      idle(1);
      chk("clr_cnt", 0, c1, 0);
      chk("clr_flag", 0, f1, 0);

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         case ($urandom_range(0, 3))
            0: begin
               rr = {$urandom, $urandom};
               x  = longint'($signed(rr[38:0]));
            end
            1: begin
               x = ($urandom_range(0, 1) == 1) ? BP : BN;
               x = x + longint'($urandom_range(0, 8)) - 4;
            end
            2: x = longint'($urandom_range(0, 33554432)) - 16777216;
            default:
               x = (longint'($urandom_range(0, 80000)) - 40000) * 4194304;
         endcase
         drive(x, $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0);
      end

      idle(5);
      for (int id = 0; id < 2; id++) chk("drain", id, q[id].size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
